// File: rtl/keccakp400_perm_ctrl.sv
// Iterative round sequencer for Keccak-p[400,nr]: owns the state register, drives the
// external combinational round stage one round per clock and hands results out via valid/ready.
module keccakp400_perm_ctrl #(
  parameter int STATE_W    = 400,
  parameter int MAX_ROUNDS = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] in_state_di,
  input  logic [4:0]         in_rounds_di,
  input  logic               in_valid_di,
  output logic               in_ready_do,
  output logic [STATE_W-1:0] out_state_do,
  output logic               out_valid_do,
  input  logic               out_ready_di,
  output logic               busy_do,
  output logic [STATE_W-1:0] rnd_state_do,
  output logic [4:0]         rnd_round_do,
  input  logic [STATE_W-1:0] rnd_state_di
);

  localparam logic [4:0] MAX_RND = 5'(MAX_ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t               fsm_p0;
  fsm_t               fsm_nxt;
  logic [STATE_W-1:0] perm_p0;
  logic [4:0]         cnt_p0;
  logic [4:0]         rounds_sat;
  logic               load;

  // Requests above the RC table depth saturate to a full-length permutation.
  function automatic logic [4:0] sat_rounds(input logic [4:0] nr);
    return (nr > MAX_RND) ? MAX_RND : nr;
  endfunction

  assign rounds_sat = sat_rounds(in_rounds_di);
  assign load       = (fsm_p0 == IDLE) && in_valid_di;

  always_ff @(posedge clk) begin
    if (rst) fsm_p0 <= IDLE;
    else     fsm_p0 <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm_p0;
    case (fsm_p0)
      IDLE: if (in_valid_di) fsm_nxt = (rounds_sat == 5'd0) ? DONE : RUN;
      RUN:  if (cnt_p0 == 5'd1) fsm_nxt = DONE;
      DONE: if (out_ready_di) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_do  = (fsm_p0 == IDLE);
    busy_do      = (fsm_p0 == RUN);
    out_valid_do = (fsm_p0 == DONE);
    // Index 0 is outside the round stage's RC table, so idle cycles park it at the top.
    rnd_round_do = (fsm_p0 == RUN) ? cnt_p0 : MAX_RND;
  end

  // Stage p0: state register and remaining-round counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      perm_p0 <= '0;
      cnt_p0  <= '0;
    end else if (load) begin
      perm_p0 <= in_state_di;
      cnt_p0  <= rounds_sat;
    end else if (fsm_p0 == RUN) begin
      perm_p0 <= rnd_state_di;
      cnt_p0  <= cnt_p0 - 5'd1;
    end
  end

  assign rnd_state_do = perm_p0;
  assign out_state_do = perm_p0;

endmodule

// File: tb/tb_keccakp400_perm_ctrl.sv
// Directed bench for keccakp400_perm_ctrl; a simple invertible stand-in round function
// (rotate-left by one, XOR round index into the low bits) closes the loop around the DUT.
module tb_keccakp400_perm_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [399:0] in_state_di;
  logic [4:0]   in_rounds_di;
  logic         in_valid_di;
  logic         in_ready_do;
  logic [399:0] out_state_do;
  logic         out_valid_do;
  logic         out_ready_di;
  logic         busy_do;
  logic [399:0] rnd_state_do;
  logic [4:0]   rnd_round_do;
  logic [399:0] rnd_state_di;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign rnd_state_di = {rnd_state_do[398:0], rnd_state_do[399]} ^ {395'd0, rnd_round_do};

  keccakp400_perm_ctrl #(.STATE_W(400), .MAX_ROUNDS(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_state_di  (in_state_di),
    .in_rounds_di (in_rounds_di),
    .in_valid_di  (in_valid_di),
    .in_ready_do  (in_ready_do),
    .out_state_do (out_state_do),
    .out_valid_do (out_valid_do),
    .out_ready_di (out_ready_di),
    .busy_do      (busy_do),
    .rnd_state_do (rnd_state_do),
    .rnd_round_do (rnd_round_do),
    .rnd_state_di (rnd_state_di)
  );

  function automatic logic [399:0] ref_perm(input logic [399:0] s, input int nr);
    int n;
    n = (nr > 20) ? 20 : nr;
    for (int r = n; r >= 1; r--) s = {s[398:0], s[399]} ^ {395'd0, 5'(r)};
    return s;
  endfunction

  function automatic logic [399:0] rand_state();
    logic [415:0] w;
    for (int i = 0; i < 13; i++) w[i*32 +: 32] = $urandom;
    return w[399:0];
  endfunction

  // Loads one state, follows it to DONE (bounded), records latency, busy and round-index
  // sequence, and optionally takes the result.
  task automatic run_perm(input logic [399:0] s, input logic [4:0] nr, input bit consume,
                          output logic [399:0] res, output int lat,
                          output bit busy_seen, output bit seq_ok);
    int r;
    r = (nr > 5'd20) ? 20 : int'(nr);
    @(negedge clk);
    in_state_di  = s;
    in_rounds_di = nr;
    in_valid_di  = 1'b1;
    out_ready_di = 1'b0;
    @(posedge clk); #1;
    in_valid_di = 1'b0;
    lat = 1;
    busy_seen = 1'b0;
    seq_ok = 1'b1;
    while (!out_valid_do && lat < 100) begin
      if (busy_do) begin
        busy_seen = 1'b1;
        if (rnd_round_do !== 5'(r)) seq_ok = 1'b0;
        r--;
      end else if (rnd_round_do !== 5'd20) seq_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (r != 0) seq_ok = 1'b0;
    if (!out_valid_do) lat = -1;
    res = out_state_do;
    if (consume) begin
      @(negedge clk);
      out_ready_di = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      out_ready_di = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready_do !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready got=%b want=1", in_ready_do); end
    n_checks++; if (out_valid_do !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid_do); end
    n_checks++; if (busy_do !== 1'b0) begin n_fails++; $display("FAIL reset_busy got=%b want=0", busy_do); end
    n_checks++; if (out_state_do !== 400'd0) begin n_fails++; $display("FAIL reset_out_state got=%h want=0", out_state_do); end
    n_checks++; if (rnd_round_do !== 5'd20) begin n_fails++; $display("FAIL reset_rnd_round got=%0d want=20", rnd_round_do); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_round();
    logic [399:0] res; int lat; bit bs, sq;
    run_perm(400'd0, 5'd1, 1'b1, res, lat, bs, sq);
    n_checks++; if (res !== 400'd1) begin n_fails++; $display("FAIL nr1_state got=%h want=1", res); end
    n_checks++; if (lat !== 2) begin n_fails++; $display("FAIL nr1_latency got=%0d want=2", lat); end
    n_checks++; if (sq !== 1'b1) begin n_fails++; $display("FAIL nr1_round_seq got=%b want=1", sq); end
    // Two rounds from zero: idx 2 gives 2, then rotl(2)=4 xor 1 = 5.
    run_perm(400'd0, 5'd2, 1'b1, res, lat, bs, sq);
    n_checks++; if (res !== 400'd5) begin n_fails++; $display("FAIL nr2_state got=%h want=5", res); end
    n_checks++; if (lat !== 3) begin n_fails++; $display("FAIL nr2_latency got=%0d want=3", lat); end
  endtask

  task automatic test_full_rounds();
    logic [399:0] res, s; int lat; bit bs, sq;
    run_perm(400'd0, 5'd20, 1'b1, res, lat, bs, sq);
    n_checks++; if (res !== ref_perm(400'd0, 20)) begin n_fails++; $display("FAIL nr20_state got=%h want=%h", res, ref_perm(400'd0, 20)); end
    n_checks++; if (lat !== 21) begin n_fails++; $display("FAIL nr20_latency got=%0d want=21", lat); end
    n_checks++; if (sq !== 1'b1) begin n_fails++; $display("FAIL nr20_round_seq got=%b want=1", sq); end
    s = rand_state();
    run_perm(s, 5'd31, 1'b1, res, lat, bs, sq);
    n_checks++; if (res !== ref_perm(s, 20)) begin n_fails++; $display("FAIL nr31_clamp_state got=%h want=%h", res, ref_perm(s, 20)); end
    n_checks++; if (lat !== 21) begin n_fails++; $display("FAIL nr31_clamp_latency got=%0d want=21", lat); end
    n_checks++; if (sq !== 1'b1) begin n_fails++; $display("FAIL nr31_round_seq got=%b want=1", sq); end
    s = rand_state();
    run_perm(s, 5'd12, 1'b1, res, lat, bs, sq);
    n_checks++; if (res !== ref_perm(s, 12)) begin n_fails++; $display("FAIL nr12_state got=%h want=%h", res, ref_perm(s, 12)); end
    s = rand_state();
    run_perm(s, 5'd8, 1'b1, res, lat, bs, sq);
    n_checks++; if (res !== ref_perm(s, 8)) begin n_fails++; $display("FAIL nr8_state got=%h want=%h", res, ref_perm(s, 8)); end
    n_checks++; if (lat !== 9) begin n_fails++; $display("FAIL nr8_latency got=%0d want=9", lat); end
  endtask

  task automatic test_pass_through();
    logic [399:0] res, s; int lat; bit bs, sq;
    s = rand_state();
    run_perm(s, 5'd0, 1'b1, res, lat, bs, sq);
    n_checks++; if (res !== s) begin n_fails++; $display("FAIL nr0_state got=%h want=%h", res, s); end
    n_checks++; if (lat !== 1) begin n_fails++; $display("FAIL nr0_latency got=%0d want=1", lat); end
    n_checks++; if (bs !== 1'b0) begin n_fails++; $display("FAIL nr0_busy got=%b want=0", bs); end
  endtask

  task automatic test_hold();
    logic [399:0] res, s, want; int lat; bit bs, sq;
    s = rand_state();
    want = ref_perm(s, 2);
    run_perm(s, 5'd2, 1'b0, res, lat, bs, sq);
    n_checks++; if (res !== want) begin n_fails++; $display("FAIL hold_initial got=%h want=%h", res, want); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_di  = i[0];
      in_state_di  = rand_state();
      in_rounds_di = 5'd0;
      @(posedge clk); #1;
      n_checks++; if (out_state_do !== want) begin n_fails++; $display("FAIL hold_state cyc=%0d got=%h want=%h", i, out_state_do, want); end
      n_checks++; if (out_valid_do !== 1'b1 || in_ready_do !== 1'b0) begin n_fails++; $display("FAIL hold_handshake cyc=%0d got v=%b r=%b want v=1 r=0", i, out_valid_do, in_ready_do); end
    end
    @(negedge clk);
    in_valid_di  = 1'b0;
    out_ready_di = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid_do !== 1'b0 || in_ready_do !== 1'b1) begin n_fails++; $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid_do, in_ready_do); end
    n_checks++; if (out_state_do !== want) begin n_fails++; $display("FAIL hold_after_release got=%h want=%h", out_state_do, want); end
    @(negedge clk);
    out_ready_di = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [399:0] s;
    int t_valid[3];
    int n_seen;
    s = rand_state();
    n_seen = 0;
    @(negedge clk);
    in_state_di  = s;
    in_rounds_di = 5'd3;
    in_valid_di  = 1'b1;
    out_ready_di = 1'b1;
    for (int cyc = 0; cyc < 60 && n_seen < 3; cyc++) begin
      @(posedge clk); #1;
      if (out_valid_do) begin
        t_valid[n_seen] = cyc;
        n_checks++; if (out_state_do !== ref_perm(s, 3)) begin n_fails++; $display("FAIL b2b_state n=%0d got=%h want=%h", n_seen, out_state_do, ref_perm(s, 3)); end
        n_seen++;
      end
    end
    @(negedge clk);
    in_valid_di  = 1'b0;
    out_ready_di = 1'b0;
    n_checks++; if (n_seen !== 3) begin n_fails++; $display("FAIL b2b_count got=%0d want=3", n_seen); end
    else begin
      n_checks++; if (t_valid[1] - t_valid[0] !== 5) begin n_fails++; $display("FAIL b2b_spacing01 got=%0d want=5", t_valid[1] - t_valid[0]); end
      n_checks++; if (t_valid[2] - t_valid[1] !== 5) begin n_fails++; $display("FAIL b2b_spacing12 got=%0d want=5", t_valid[2] - t_valid[1]); end
    end
    repeat (6) @(posedge clk);
    if (!in_ready_do) begin
      @(negedge clk); out_ready_di = 1'b1;
      @(posedge clk); @(negedge clk); out_ready_di = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [399:0] res, s; int lat; bit bs, sq;
    @(negedge clk);
    in_state_di  = rand_state();
    in_rounds_di = 5'd20;
    in_valid_di  = 1'b1;
    @(posedge clk); #1;
    in_valid_di = 1'b0;
    n_checks++; if (busy_do !== 1'b1) begin n_fails++; $display("FAIL abort_busy_start got=%b want=1", busy_do); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready_do !== 1'b1 || busy_do !== 1'b0 || out_valid_do !== 1'b0) begin n_fails++; $display("FAIL abort_ctrl got r=%b b=%b v=%b want r=1 b=0 v=0", in_ready_do, busy_do, out_valid_do); end
    n_checks++; if (out_state_do !== 400'd0) begin n_fails++; $display("FAIL abort_state got=%h want=0", out_state_do); end
    n_checks++; if (rnd_round_do !== 5'd20) begin n_fails++; $display("FAIL abort_rnd_round got=%0d want=20", rnd_round_do); end
    @(negedge clk);
    rst = 1'b0;
    s = rand_state();
    run_perm(s, 5'd12, 1'b1, res, lat, bs, sq);
    n_checks++; if (res !== ref_perm(s, 12)) begin n_fails++; $display("FAIL abort_reload got=%h want=%h", res, ref_perm(s, 12)); end
    n_checks++; if (lat !== 13) begin n_fails++; $display("FAIL abort_reload_latency got=%0d want=13", lat); end
  endtask

  initial begin
    rst          = 1'b1;
    in_state_di  = '0;
    in_rounds_di = '0;
    in_valid_di  = 1'b0;
    out_ready_di = 1'b0;
    test_reset();
    test_single_round();
    test_full_rounds();
    test_pass_through();
    test_hold();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
